uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
//   Generates the per-bit enable tick (tx_enb) for the transmitter.
//   Sequences each frame: load the byte, wait for the frame to start, wait for it to finish, then re-arbitrate.
//   Sits between the host-side byte sources and the transmitter (wr_enb/enb/data_in/busy).
// PARAMETERS
//   NUM_REQ       4    number of requesters, >=1
//   CLKS_PER_BIT  868  clk cycles per serial bit, >=2 (100 MHz / 115200)
//   ID_W          2    grant id width = max(1, $clog2(NUM_REQ))
// PORTS
//   clk        in   1            system clock
//   rst_n      in   1            asynchronous, active-low reset
//   req_valid  in   NUM_REQ      per-requester byte valid
//   req_data   in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]
//   req_ready  out  NUM_REQ      one-hot accept pulse; transfer occurs on valid&ready
//   tx_wr_enb  out  1            load strobe to transmitter, 1 cycle
//   tx_data    out  8            byte to transmitter
//   tx_enb     out  1            bit-period tick to transmitter, 1-cycle pulse
//   tx_busy    in   1            transmitter busy
//   grant_id   out  ID_W         index of current/last granted requester
//   active     out  1            scheduler not in IDLE
//   err        out  1            1-cycle pulse: transmitter failed to go busy after load
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; bit counter=0; last-grant pointer=NUM_REQ-1.
//     All outputs are 0 during reset: req_ready, tx_wr_enb, tx_data, tx_enb, grant_id, active, err.
//   States: IDLE -> LOAD -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   IDLE
//     - Arbitrates only when tx_busy==0 and |req_valid.
//     - Winner is the first valid index searching upward from (last+1) mod NUM_REQ.
//     - On the edge: register grant_id=winner, tx_data=req_data[winner], last=winner; go to LOAD.
//     - With tx_busy==1, no grant is made regardless of req_valid.
//   LOAD (exactly 1 cycle)
//     - tx_wr_enb=1; req_ready[grant_id]=1, all other ready bits 0.
//     - Bit counter cleared; go to WAIT_BUSY.
//   WAIT_BUSY
//     - tx_busy==1: go to WAIT_DONE.
//     - tx_busy still 0 after 2 cycles in this state: err pulse, go to IDLE.
//   WAIT_DONE
//     - Stays until tx_busy==0, then goes to IDLE.
//     - Re-arbitration happens in IDLE on the following cycle.
//   Bit counter
//     - Runs 0..CLKS_PER_BIT-1 and wraps, in WAIT_BUSY/WAIT_DONE only; held at 0 elsewhere.
//     - tx_enb=1 for one cycle when counter==CLKS_PER_BIT-1 in those states.
//     - First tick comes CLKS_PER_BIT cycles after LOAD; a full frame is 10 ticks.
//   Requester rules
//     - valid and data must stay stable until ready is seen; valid may not drop early.
//     - A requester with valid held high is re-eligible only after all other valid requesters are served.
//   Latency: valid sampled in IDLE -> ready/tx_wr_enb on the next cycle.
//   tx_data holds its value until the next grant.
//   active=1 in every state except IDLE.
//   Reset mid-frame: scheduler returns to IDLE at once. No new grant is made until tx_busy==0, so no corrupt overlap.
//   NUM_REQ==1: arbitration degenerates to a pass-through; grant_id stays 0.
// STRUCTURE
//   uart_pkg holds:
//     - state encoding localparams (IDLE/LOAD/WAIT_BUSY/WAIT_DONE)
//     - BUSY_TIMEOUT=2
//     - function clog2_min1
//   Sub-module uart_baud_tick (counter + tick, inputs run/clear) is instantiated once.
//   Round-robin search stays inline.
// TESTING (NUM_REQ=4, CLKS_PER_BIT=4, real transmitter attached, rst=~rst_n)
//   1. req0 valid, data 0xA5 -> ready[0] and tx_wr_enb 1 cycle later, tx_data=0xA5.
//      10 tx_enb ticks spaced 4 cycles; serial line 0,1,0,1,0,0,1,0,1,1.
//   2. req0..3 valid together -> grants 0,1,2,3, one per frame; tx_wr_enb never pulses while tx_busy=1.
//   3. req1, req3 held valid continuously -> grant order 1,3,1,3; req0/req2 never readied.
//   4. tx_busy tied 0 after LOAD -> err pulse 2 cycles after WAIT_BUSY entry; back to IDLE; ready pulsed once.
//   5. tx_busy forced 1 in IDLE with req2 valid -> no ready, active=0; busy drops -> grant 2 next cycle.
//   6. rst_n low mid-WAIT_DONE -> all outputs 0 immediately.
//      After release, first grant after tx_busy=0 goes to req0 (pointer reset).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding,
// busy-timeout length and a width helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LOAD      = ST_LOAD,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_t;

    // Cycles allowed in WAIT_BUSY for the transmitter to acknowledge a load.
    localparam int BUSY_TIMEOUT = 2;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and pulses
// tick on the last count; held at zero when idle or cleared.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources; sequences load / start / finish of each frame and drives tx_enb.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int ID_W         = clog2_min1(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_wr_enb,
    output logic [7:0]           tx_data,
    output logic                 tx_enb,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 err
);

    localparam int TO_W = clog2_min1(BUSY_TIMEOUT);

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] winner;
    logic [7:0]      win_data;
    logic            found;
    logic            grant_go;
    logic [TO_W-1:0] wb_cnt;
    logic            baud_run;
    logic            baud_clr;

    // Search above the last grant first, then wrap to the lowest index.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && i > int'(last_q)) begin
                found    = 1'b1;
                winner   = ID_W'(i);
                win_data = req_data[8*i +: 8];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                winner   = ID_W'(i);
                win_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && found) begin
                    grant_go  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wb_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
            tx_data  <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
        end else if (grant_go) begin
            grant_id <= winner;
            tx_data  <= win_data;
            last_q   <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt <= '0;
        end else if (state == WAIT_BUSY) begin
            wb_cnt <= wb_cnt + 1'b1;
        end else begin
            wb_cnt <= '0;
        end
    end

    assign baud_run = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign baud_clr = (state == LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (baud_run),
        .clear (baud_clr),
        .tick  (tx_enb)
    );

    assign tx_wr_enb = (state == LOAD);
    assign req_ready = (state == LOAD) ? (NUM_REQ'(1) << grant_id) : '0;
    assign active    = (state != IDLE);

endmodule
